// File: rtl/motion_pkg.sv
// motion_pkg: shared defaults, widths, FSM states and the
// window popcount helper for the motion centroid tracker.
package motion_pkg;

  localparam int DEF_IMAGE_W = 320;
  localparam int DEF_IMAGE_H = 240;
  localparam int DEF_X_WIDTH = 9;
  localparam int DEF_Y_WIDTH = 8;

  localparam int CNT_W = 17;
  localparam int SUM_W = 26;

  typedef enum logic [2:0] {
    STREAM,
    CHECK,
    DIVX,
    DIVY,
    SMOOTH,
    MARKER
  } state_t;

  function automatic logic [3:0] popcount9(
    input logic [8:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 9; k++) begin
      n = n + {3'b000, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit
// per cycle, start/busy/done handshake.
module seq_divider #(
  parameter int DIVIDEND_W = 26,
  parameter int DIVISOR_W  = 17,
  parameter int QUOT_W     = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] acc;
  logic [DIVISOR_W-1:0]  rem;
  logic [CW-1:0]         cnt;
  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W:0]    diff;
  logic                  ge;

  // acc shifts the dividend out and the quotient in
  assign shifted  = {rem, acc[DIVIDEND_W-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign ge       = shifted >= {1'b0, divisor};
  assign quotient = acc[QUOT_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      acc  <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        acc  <= dividend;
        rem  <= '0;
        cnt  <= CW'(DIVIDEND_W);
      end else if (busy) begin
        acc <= {acc[DIVIDEND_W-2:0], ge};
        rem <= ge ? diff[DIVISOR_W-1:0]
                  : shifted[DIVISOR_W-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/motion_centroid_tracker.sv
// motion_centroid_tracker: 3x3 erosion, centroid stats, IIR
// smoothing, marker draw. MOTION_TRACKER_BBOX_EN adds bbox.
module motion_centroid_tracker
  import motion_pkg::*;
#(
  parameter int IMAGE_W      = DEF_IMAGE_W,
  parameter int IMAGE_H      = DEF_IMAGE_H,
  parameter int X_WIDTH      = DEF_X_WIDTH,
  parameter int Y_WIDTH      = DEF_Y_WIDTH,
  parameter int ERODE_THRESH = 9,
  parameter int MIN_COUNT    = 300,
  parameter int SMOOTH_SHIFT = 2,
  parameter int MARKER_SIZE  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_WIDTH-1:0] in_x,
  input  logic [Y_WIDTH-1:0] in_y,
  input  logic               in_bit,
  input  logic               enable_smoothing,
  output logic               vga_plot,
  output logic [X_WIDTH-1:0] vga_x,
  output logic [Y_WIDTH-1:0] vga_y,
  output logic               vga_colour,
  output logic [X_WIDTH-1:0] centroid_x,
  output logic [Y_WIDTH-1:0] centroid_y,
  output logic               centroid_valid
`ifdef MOTION_TRACKER_BBOX_EN
  ,
  output logic [X_WIDTH-1:0] bbox_xmin,
  output logic [X_WIDTH-1:0] bbox_xmax,
  output logic [Y_WIDTH-1:0] bbox_ymin,
  output logic [Y_WIDTH-1:0] bbox_ymax
`endif
);

  localparam int MW =
    (MARKER_SIZE > 1) ? $clog2(MARKER_SIZE) : 1;
  localparam logic [X_WIDTH-1:0] X_TWO  = X_WIDTH'(2);
  localparam logic [Y_WIDTH-1:0] Y_TWO  = Y_WIDTH'(2);
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMAGE_W-1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMAGE_H-1);
  localparam logic [X_WIDTH:0]   X_LIM  = (X_WIDTH+1)'(IMAGE_W);
  localparam logic [Y_WIDTH:0]   Y_LIM  = (Y_WIDTH+1)'(IMAGE_H);
  localparam logic [3:0]         THR    = 4'(ERODE_THRESH);
  localparam logic [CNT_W-1:0]   MIN_C  = CNT_W'(MIN_COUNT);
  localparam logic [MW-1:0]      M_LAST = MW'(MARKER_SIZE-1);

  state_t state;

  logic accept, first_px, last_px, inner, colour_c;
  logic old_mid, old_top;
  logic [2:0] win_top, win_mid, win_bot;
  logic [2:0] nxt_top, nxt_mid, nxt_bot;
  logic lb_mid [IMAGE_W];
  logic lb_top [IMAGE_W];
  logic [X_WIDTH-1:0] cx;
  logic [Y_WIDTH-1:0] cy;

  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] sum_x, sum_y, dividend;
  logic [X_WIDTH-1:0] avg_x, q_x, quot;
  logic [Y_WIDTH-1:0] avg_y, q_y;
  logic launch, div_start, div_busy, div_done;

  logic [MW-1:0] mi, mj;
  logic [X_WIDTH:0] mk_px;
  logic [Y_WIDTH:0] mk_py;
  logic mk_on, sq_last, mk_done;

  assign accept   = in_valid & in_ready;
  assign first_px = (in_x == '0) && (in_y == '0);
  assign last_px  = (in_x == X_LAST) && (in_y == Y_LAST);
  assign inner    = (in_x >= X_TWO) && (in_x <= X_LAST)
                 && (in_y >= Y_TWO) && (in_y <= Y_LAST);
  assign cx       = in_x - X_WIDTH'(1);
  assign cy       = in_y - Y_WIDTH'(1);

  // bit 2 is column x, bit 1 the centre column x-1
  assign old_mid = lb_mid[in_x];
  assign old_top = lb_top[in_x];
  assign nxt_top = {old_top, win_top[2:1]};
  assign nxt_mid = {old_mid, win_mid[2:1]};
  assign nxt_bot = {in_bit,  win_bot[2:1]};

  assign colour_c = enable_smoothing
    ? (popcount9({nxt_top, nxt_mid, nxt_bot}) >= THR)
    : nxt_mid[1];

  assign centroid_x = avg_x;
  assign centroid_y = avg_y;

  always_ff @(posedge clock) begin
    if (accept) begin
      lb_mid[in_x] <= in_bit;
      lb_top[in_x] <= old_mid;
    end
  end

  assign dividend  = (state == DIVY) ? sum_y : sum_x;
  assign div_start = launch & ~div_busy;

  seq_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W),
    .QUOT_W     (X_WIDTH)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (count),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quot)
  );

  assign sq_last = (mi == M_LAST) && (mj == M_LAST);

`ifdef MOTION_TRACKER_BBOX_EN
  logic [2:0] edge_sel;
  logic [X_WIDTH-1:0] ex, trk_xmin, trk_xmax;
  logic [Y_WIDTH-1:0] ey, trk_ymin, trk_ymax;

  assign mk_done = (edge_sel == 3'd4) && (ey == bbox_ymax);

  always_comb begin
    mk_px = {1'b0, avg_x} + (X_WIDTH+1)'(mi);
    mk_py = {1'b0, avg_y} + (Y_WIDTH+1)'(mj);
    case (edge_sel)
      3'd1: begin
        mk_px = {1'b0, ex};
        mk_py = {1'b0, bbox_ymin};
      end
      3'd2: begin
        mk_px = {1'b0, ex};
        mk_py = {1'b0, bbox_ymax};
      end
      3'd3: begin
        mk_px = {1'b0, bbox_xmin};
        mk_py = {1'b0, ey};
      end
      3'd4: begin
        mk_px = {1'b0, bbox_xmax};
        mk_py = {1'b0, ey};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_sel  <= '0;
      ex        <= '0;
      ey        <= '0;
      trk_xmin  <= '0;
      trk_xmax  <= '0;
      trk_ymin  <= '0;
      trk_ymax  <= '0;
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
    end else begin
      if (accept && first_px) begin
        trk_xmin <= '1;
        trk_xmax <= '0;
        trk_ymin <= '1;
        trk_ymax <= '0;
      end else if (accept && inner && colour_c) begin
        if (cx < trk_xmin) trk_xmin <= cx;
        if (cx > trk_xmax) trk_xmax <= cx;
        if (cy < trk_ymin) trk_ymin <= cy;
        if (cy > trk_ymax) trk_ymax <= cy;
      end
      if (state == SMOOTH) begin
        bbox_xmin <= trk_xmin;
        bbox_xmax <= trk_xmax;
        bbox_ymin <= trk_ymin;
        bbox_ymax <= trk_ymax;
        edge_sel  <= '0;
      end
      // outline order: top, bottom, left, right
      if (state == MARKER) begin
        case (edge_sel)
          3'd0:
            if (sq_last) begin
              edge_sel <= 3'd1;
              ex       <= bbox_xmin;
            end
          3'd1:
            if (ex == bbox_xmax) begin
              edge_sel <= 3'd2;
              ex       <= bbox_xmin;
            end else ex <= ex + 1'b1;
          3'd2:
            if (ex == bbox_xmax) begin
              edge_sel <= 3'd3;
              ey       <= bbox_ymin;
            end else ex <= ex + 1'b1;
          3'd3:
            if (ey == bbox_ymax) begin
              edge_sel <= 3'd4;
              ey       <= bbox_ymin;
            end else ey <= ey + 1'b1;
          default:
            if (ey != bbox_ymax) ey <= ey + 1'b1;
        endcase
      end
    end
  end
`else
  assign mk_done = sq_last;

  always_comb begin
    mk_px = {1'b0, avg_x} + (X_WIDTH+1)'(mi);
    mk_py = {1'b0, avg_y} + (Y_WIDTH+1)'(mj);
  end
`endif

  assign mk_on = (mk_px < X_LIM) && (mk_py < Y_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= STREAM;
      in_ready       <= 1'b0;
      vga_plot       <= 1'b0;
      vga_x          <= '0;
      vga_y          <= '0;
      vga_colour     <= 1'b0;
      centroid_valid <= 1'b0;
      avg_x          <= '0;
      avg_y          <= '0;
      q_x            <= '0;
      q_y            <= '0;
      count          <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      launch         <= 1'b0;
      mi             <= '0;
      mj             <= '0;
      win_top        <= '0;
      win_mid        <= '0;
      win_bot        <= '0;
    end else begin
      vga_plot       <= 1'b0;
      centroid_valid <= 1'b0;
      launch         <= 1'b0;
      unique case (state)
        STREAM: begin
          in_ready <= 1'b1;
          if (accept) begin
            win_top    <= nxt_top;
            win_mid    <= nxt_mid;
            win_bot    <= nxt_bot;
            vga_plot   <= inner;
            vga_x      <= cx;
            vga_y      <= cy;
            vga_colour <= colour_c;
            if (first_px) begin
              count <= '0;
              sum_x <= '0;
              sum_y <= '0;
            end else if (inner && colour_c) begin
              count <= count + 1'b1;
              sum_x <= sum_x + SUM_W'(cx);
              sum_y <= sum_y + SUM_W'(cy);
            end
            if (last_px) begin
              state    <= CHECK;
              in_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (count < MIN_C) begin
            state    <= STREAM;
            in_ready <= 1'b1;
          end else begin
            state  <= DIVX;
            launch <= 1'b1;
          end
        end
        DIVX: begin
          if (div_done) begin
            q_x    <= quot;
            state  <= DIVY;
            launch <= 1'b1;
          end
        end
        DIVY: begin
          if (div_done) begin
            q_y   <= quot[Y_WIDTH-1:0];
            state <= SMOOTH;
          end
        end
        SMOOTH: begin
          avg_x <= avg_x + (q_x >> SMOOTH_SHIFT)
                         - (avg_x >> SMOOTH_SHIFT);
          avg_y <= avg_y + (q_y >> SMOOTH_SHIFT)
                         - (avg_y >> SMOOTH_SHIFT);
          centroid_valid <= 1'b1;
          mi    <= '0;
          mj    <= '0;
          state <= MARKER;
        end
        MARKER: begin
          vga_plot   <= mk_on;
          vga_x      <= mk_px[X_WIDTH-1:0];
          vga_y      <= mk_py[Y_WIDTH-1:0];
          vga_colour <= 1'b1;
          if (mi == M_LAST) begin
            mi <= '0;
            mj <= mj + 1'b1;
          end else begin
            mi <= mi + 1'b1;
          end
          if (mk_done) begin
            state    <= STREAM;
            in_ready <= 1'b1;
          end
        end
        default: state <= STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_centroid_tracker.sv
// Directed bench for motion_centroid_tracker on a reduced
// 48x32 image so whole frames stay short.
module tb_motion_centroid_tracker;

  localparam int W = 48;
  localparam int H = 32;
  localparam int INNER = (W - 2) * (H - 2);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic       in_bit = 1'b0;
  logic       enable_smoothing = 1'b1;
  logic       vga_plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic       vga_colour;
  logic [8:0] centroid_x;
  logic [7:0] centroid_y;
  logic       centroid_valid;
`ifdef MOTION_TRACKER_BBOX_EN
  logic [8:0] bbox_xmin, bbox_xmax;
  logic [7:0] bbox_ymin, bbox_ymax;
`endif

  always #5 clock = ~clock;

  motion_centroid_tracker #(
    .IMAGE_W (W),
    .IMAGE_H (H)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_x             (in_x),
    .in_y             (in_y),
    .in_bit           (in_bit),
    .enable_smoothing (enable_smoothing),
    .vga_plot         (vga_plot),
    .vga_x            (vga_x),
    .vga_y            (vga_y),
    .vga_colour       (vga_colour),
    .centroid_x       (centroid_x),
    .centroid_y       (centroid_y),
    .centroid_valid   (centroid_valid)
`ifdef MOTION_TRACKER_BBOX_EN
    ,
    .bbox_xmin        (bbox_xmin),
    .bbox_xmax        (bbox_xmax),
    .bbox_ymin        (bbox_ymin),
    .bbox_ymax        (bbox_ymax)
`endif
  );

  int checks = 0;
  int errors = 0;
  int tot_plot = 0;
  int tot_one = 0;
  int tot_col0 = 0;
  int tot_cv = 0;
  int ax = 0;
  int ay = 0;
  logic [8:0] hist_x [16];
  logic [7:0] hist_y [16];
  logic       hist_c [16];

  // plot monitor; keeps the last 16 plots in a ring
  always @(negedge clock) begin
    if (vga_plot) begin
      hist_x[tot_plot[3:0]] = vga_x;
      hist_y[tot_plot[3:0]] = vga_y;
      hist_c[tot_plot[3:0]] = vga_colour;
      tot_plot++;
      if (vga_colour) tot_one++;
      if (vga_x == 9'd0) tot_col0++;
    end
    if (centroid_valid) tot_cv++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic pix(input int mode,
                               input int x, input int y);
    case (mode)
      1: return x >= 20 && x <= 39 && y >= 5 && y <= 24;
      2: return (x == 10 && y == 10) ||
                (x == 20 && y == 15) ||
                (x == 30 && y == 20);
      3: return x <= 19 && y >= 5 && y <= 24;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_pixel(input int x, input int y,
                            input logic b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x = 9'(x);
    in_y = 8'(y);
    in_bit = b;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n == 200) chk("accept_wait", in_ready, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send_pixel(x, y, pix(mode, x, y));
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    chk("ready_return", in_ready, 1);
    tick();
  endtask

  // 18x18 eroded pixels plus 16 on-image marker plots
  task automatic block_frame(input int mode,
                             input int qx, input int qy,
                             input string tag);
    int o, c;
    o = tot_one;
    c = tot_cv;
    send_frame(mode);
    wait_ready();
    ax = ax + (qx >> 2) - (ax >> 2);
    ay = ay + (qy >> 2) - (ay >> 2);
    chk({tag, "_ones"}, tot_one - o, 340);
    chk({tag, "_cv"}, tot_cv - c, 1);
    chk({tag, "_cx"}, centroid_x, ax);
    chk({tag, "_cy"}, centroid_y, ay);
  endtask

  initial begin
    int p, o, c, z, idx;

    repeat (3) tick();
    chk("rst_plot", vga_plot, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_vx", vga_x, 0);
    chk("rst_vy", vga_y, 0);
    chk("rst_cx", centroid_x, 0);
    chk("rst_cy", centroid_y, 0);
    chk("rst_cv", centroid_valid, 0);
    chk("rst_rdy", in_ready, 0);
    reset = 1'b0;
    chk("rdy_after_deassert", in_ready, 0);
    tick();
    chk("rdy_up", in_ready, 1);

    p = tot_plot;
    o = tot_one;
    c = tot_cv;
    send_frame(0);
    chk("zero_rdy_low", in_ready, 0);
    tick();
    chk("zero_rdy_back", in_ready, 1);
    tick();
    chk("zero_plots", tot_plot - p, INNER);
    chk("zero_ones", tot_one - o, 0);
    chk("zero_cv", tot_cv - c, 0);
    chk("zero_cx", centroid_x, 0);
    chk("zero_cy", centroid_y, 0);

    // q = (29,14): first frame from zero gives (7,3)
    block_frame(1, 29, 14, "blk1");
    chk("blk1_cx_hand", centroid_x, 7);
    chk("blk1_cy_hand", centroid_y, 3);
    for (int k = 0; k < 16; k++) begin
      idx = tot_plot + k;
      chk("mk_x", hist_x[idx[3:0]], 7 + (k % 4));
      chk("mk_y", hist_y[idx[3:0]], 3 + (k / 4));
      chk("mk_c", hist_c[idx[3:0]], 1);
    end
    for (int f = 2; f <= 8; f++)
      block_frame(1, 29, 14, $sformatf("blk%0d", f));
    chk("conv_cx", centroid_x, 26);
    chk("conv_cy", centroid_y, 12);

    p = tot_plot;
    o = tot_one;
    c = tot_cv;
    send_frame(2);
    wait_ready();
    chk("iso_plots", tot_plot - p, INNER);
    chk("iso_ones", tot_one - o, 0);
    enable_smoothing = 1'b0;
    o = tot_one;
    send_frame(2);
    wait_ready();
    chk("raw_ones", tot_one - o, 3);
    chk("iso_cv", tot_cv - c, 0);
    chk("iso_cx", centroid_x, 26);
    chk("iso_cy", centroid_y, 12);
    enable_smoothing = 1'b1;

    z = tot_col0;
    block_frame(3, 9, 14, "edge");
    chk("edge_col0", tot_col0 - z, 0);

    c = tot_cv;
    send_frame(1);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("abort_cx", centroid_x, 0);
    chk("abort_cy", centroid_y, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_plot", vga_plot, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("abort_rdy_low", in_ready, 0);
    tick();
    chk("abort_rdy_up", in_ready, 1);
    chk("abort_no_cv", tot_cv - c, 0);
    ax = 0;
    ay = 0;
    block_frame(1, 29, 14, "post");
    chk("post_cx_hand", centroid_x, 7);
    chk("post_cy_hand", centroid_y, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
